// File: rtl/pr_hrav_pkg.sv
// pr_hrav_pkg: shared sequencer state encoding, status codes and timer sizing helpers
package pr_hrav_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_RESET  = 3'd2,
    S_CONFIG = 3'd3,
    S_HOLD   = 3'd4,
    S_ENABLE = 3'd5,
    S_REPORT = 3'd6
  } state_t;
  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DRAIN_TO = 2'b01,
    ST_CFG_ERR  = 2'b10,
    ST_CFG_TO   = 2'b11
  } status_t;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  function automatic int clog2_min1(int v);
    return v > 2 ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/pr_hrav_timeout_cnt.sv
// pr_hrav_timeout_cnt: shared state timer; ACLK/a_reset, clr wins over en, hit when count equals tc
module pr_hrav_timeout_cnt #(
  parameter int W = 4
) (
  input  logic         ACLK,
  input  logic         a_reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         hit
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge ACLK) cnt_q <= a_reset ? '0 : cnt_d;
  assign hit = cnt_q == tc;
endmodule

// File: rtl/pr_hrav_reconfig_sequencer.sv
// pr_hrav_reconfig_sequencer: drain/reset/configure/hold/enable sequencer for two scanner cores; req in, cfg handshake, core_dis/core_rst, status pulse, debug state and OK counter out
module pr_hrav_reconfig_sequencer
  import pr_hrav_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int CFG_TIMEOUT   = 1048576,
  parameter int RST_HOLD      = 16
) (
  input  logic        ACLK,
  input  logic        a_reset,
  input  logic        req_valid,
  input  logic        req_core,
  output logic        req_ready,
  input  logic [1:0]  core_busy,
  output logic        cfg_start,
  input  logic        cfg_done,
  input  logic        cfg_error,
  output logic [1:0]  core_dis,
  output logic [1:0]  core_rst,
  output logic        status_valid,
  output logic [1:0]  status_code,
  output logic        status_core,
  output logic [2:0]  seq_state,
  output logic [15:0] reconfig_cnt
);
  localparam int TW = clog2_min1(max3(DRAIN_TIMEOUT, CFG_TIMEOUT, RST_HOLD));
  localparam logic [TW-1:0] DRAIN_TC = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] CFG_TC   = TW'(CFG_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_TC  = TW'(RST_HOLD - 1);
  state_t      state_q, state_d;
  status_t     code_q, code_d;
  logic        tgt_q, tgt_d;
  logic        req_ready_q, cfg_start_q, status_valid_q;
  logic [1:0]  core_dis_q, core_dis_d, core_rst_q, core_rst_d;
  logic [15:0] reconfig_cnt_q, reconfig_cnt_d;
  logic [TW-1:0] tc;
  logic        hit;
  pr_hrav_timeout_cnt #(.W(TW)) u_timer (
    .ACLK    (ACLK),
    .a_reset (a_reset),
    .clr     (state_d != state_q),
    .en      (state_q != S_IDLE),
    .tc      (tc),
    .hit     (hit)
  );
  always_comb tc = state_q == S_DRAIN ? DRAIN_TC : state_q == S_CONFIG ? CFG_TC : HOLD_TC;
  // Output registers are loaded from the next-state decode, so each
  // state's outputs are visible during that state's own cycles.
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    tgt_d          = tgt_q;
    core_dis_d     = core_dis_q;
    core_rst_d     = core_rst_q;
    reconfig_cnt_d = reconfig_cnt_q;
    case (state_q)
      S_IDLE: if (req_valid && req_ready_q) begin
        state_d              = S_DRAIN;
        tgt_d                = req_core;
        core_dis_d[req_core] = 1'b1;
      end
      S_DRAIN: if (!core_busy[tgt_q]) begin
        state_d           = S_RESET;
        core_rst_d[tgt_q] = 1'b1;
      end else if (hit) begin
        state_d           = S_REPORT;
        code_d            = ST_DRAIN_TO;
        core_dis_d[tgt_q] = 1'b0;
      end
      S_RESET: state_d = S_CONFIG;
      S_CONFIG: if (cfg_error) begin
        state_d = S_REPORT;
        code_d  = ST_CFG_ERR;
      end else if (cfg_done) state_d = S_HOLD;
      else if (hit) begin
        state_d = S_REPORT;
        code_d  = ST_CFG_TO;
      end
      S_HOLD: if (hit) begin
        state_d           = S_ENABLE;
        core_rst_d[tgt_q] = 1'b0;
        core_dis_d[tgt_q] = 1'b0;
        reconfig_cnt_d    = reconfig_cnt_q + 16'd1;
      end
      S_ENABLE: begin
        state_d = S_REPORT;
        code_d  = ST_OK;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (a_reset) begin
      state_q        <= S_IDLE;
      code_q         <= ST_OK;
      tgt_q          <= 1'b0;
      req_ready_q    <= 1'b1;
      cfg_start_q    <= 1'b0;
      status_valid_q <= 1'b0;
      core_dis_q     <= 2'b00;
      core_rst_q     <= 2'b00;
      reconfig_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      tgt_q          <= tgt_d;
      req_ready_q    <= state_d == S_IDLE;
      cfg_start_q    <= state_d == S_RESET;
      status_valid_q <= state_d == S_REPORT;
      core_dis_q     <= core_dis_d;
      core_rst_q     <= core_rst_d;
      reconfig_cnt_q <= reconfig_cnt_d;
    end
  end
  assign req_ready    = req_ready_q;
  assign cfg_start    = cfg_start_q;
  assign status_valid = status_valid_q;
  assign status_code  = code_q;
  assign status_core  = tgt_q;
  assign seq_state    = state_q;
  assign core_dis     = core_dis_q;
  assign core_rst     = core_rst_q;
  assign reconfig_cnt = reconfig_cnt_q;
endmodule

// File: tb/tb_pr_hrav_reconfig_sequencer.sv
// tb_pr_hrav_reconfig_sequencer: directed self-checking bench for the reconfiguration sequencer
module tb_pr_hrav_reconfig_sequencer;
  logic        ACLK = 1'b0;
  logic        a_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_core = 1'b0;
  logic        req_ready;
  logic [1:0]  core_busy = 2'b00;
  logic        cfg_start;
  logic        cfg_done = 1'b0;
  logic        cfg_error = 1'b0;
  logic [1:0]  core_dis, core_rst;
  logic        status_valid;
  logic [1:0]  status_code;
  logic        status_core;
  logic [2:0]  seq_state;
  logic [15:0] reconfig_cnt;
  int errors = 0;
  int checks = 0;
  int n, rh, cs;
  pr_hrav_reconfig_sequencer #(.DRAIN_TIMEOUT(8), .CFG_TIMEOUT(32), .RST_HOLD(16)) dut (
    .ACLK(ACLK), .a_reset(a_reset), .req_valid(req_valid), .req_core(req_core),
    .req_ready(req_ready), .core_busy(core_busy), .cfg_start(cfg_start),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .core_dis(core_dis), .core_rst(core_rst),
    .status_valid(status_valid), .status_code(status_code), .status_core(status_core),
    .seq_state(seq_state), .reconfig_cnt(reconfig_cnt)
  );
  always #5 ACLK = ~ACLK;
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic req(input logic c);
    req_valid = 1'b1;
    req_core = c;
    step();
    req_valid = 1'b0;
  endtask
  task automatic wait_status(input int done_at, input int bound);
    n = 0;
    rh = int'(core_rst[1]);
    cs = int'(cfg_start);
    while (!status_valid && n < bound) begin
      cfg_done = (n + 1 == done_at);
      step();
      cfg_done = 1'b0;
      n++;
      rh += int'(core_rst[1]);
      cs += int'(cfg_start);
    end
    chk("status_wait", 32'(status_valid), 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(seq_state), 0);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_start"}, 32'(cfg_start), 0);
    chk({tag, "_dis"}, 32'(core_dis), 0);
    chk({tag, "_rst"}, 32'(core_rst), 0);
    chk({tag, "_sv"}, 32'(status_valid), 0);
    chk({tag, "_code"}, 32'(status_code), 0);
    chk({tag, "_core"}, 32'(status_core), 0);
    chk({tag, "_cnt"}, 32'(reconfig_cnt), 0);
  endtask
  initial begin
    step();
    step();
    a_reset = 1'b0;
    chk_reset_vals("por");
    // core 1 success, cfg_done 10 cycles after cfg_start
    req(1'b1);
    chk("t1_drain", 32'(seq_state), 1);
    chk("t1_dis", 32'(core_dis), 2);
    chk("t1_ready", 32'(req_ready), 0);
    step();
    chk("t1_reset", 32'(seq_state), 2);
    chk("t1_start", 32'(cfg_start), 1);
    chk("t1_rst", 32'(core_rst), 2);
    wait_status(11, 60);
    chk("t1_lat", n, 28);
    chk("t1_rsthigh", rh, 27);
    chk("t1_starts", cs, 1);
    chk("t1_code", 32'(status_code), 0);
    chk("t1_core", 32'(status_core), 1);
    chk("t1_cnt", 32'(reconfig_cnt), 1);
    chk("t1_dis_end", 32'(core_dis), 0);
    chk("t1_rst_end", 32'(core_rst), 0);
    step();
    chk("t1_idle", 32'(seq_state), 0);
    chk("t1_sv_once", 32'(status_valid), 0);
    // core 0 drain timeout
    core_busy = 2'b01;
    req(1'b0);
    chk("t2_dis", 32'(core_dis), 1);
    wait_status(0, 40);
    chk("t2_lat", n, 8);
    chk("t2_starts", cs, 0);
    chk("t2_code", 32'(status_code), 1);
    chk("t2_core", 32'(status_core), 0);
    chk("t2_dis_end", 32'(core_dis), 0);
    chk("t2_rst_end", 32'(core_rst), 0);
    chk("t2_cnt", 32'(reconfig_cnt), 1);
    step();
    // busy drops on the last allowed drain cycle: drain completes
    req(1'b0);
    for (int i = 0; i < 7; i++) step();
    core_busy = 2'b00;
    step();
    chk("t3_busy_wins", 32'(seq_state), 2);
    chk("t3_start", 32'(cfg_start), 1);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    chk("t3_stray_done", 32'(seq_state), 3);
    cfg_done = 1'b1;
    cfg_error = 1'b1;
    step();
    cfg_done = 1'b0;
    cfg_error = 1'b0;
    chk("t3_sv", 32'(status_valid), 1);
    chk("t3_code", 32'(status_code), 2);
    chk("t3_dis", 32'(core_dis), 1);
    chk("t3_rst", 32'(core_rst), 1);
    step();
    chk("t3_idle", 32'(seq_state), 0);
    chk("t3_dis_idle", 32'(core_dis), 1);
    chk("t3_rst_idle", 32'(core_rst), 1);
    chk("t3_cnt", 32'(reconfig_cnt), 1);
    // core 1 config timeout while core 0 stays disabled
    req(1'b1);
    chk("t4_dis", 32'(core_dis), 3);
    step();
    step();
    chk("t4_config", 32'(seq_state), 3);
    wait_status(0, 60);
    chk("t4_lat", n, 32);
    chk("t4_code", 32'(status_code), 3);
    chk("t4_core", 32'(status_core), 1);
    chk("t4_dis", 32'(core_dis), 3);
    chk("t4_rst", 32'(core_rst), 3);
    step();
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    chk("t4_ignore_state", 32'(seq_state), 0);
    chk("t4_ignore_sv", 32'(status_valid), 0);
    chk("t4_ignore_rst", 32'(core_rst), 3);
    // reset during HOLD, then a fresh sequence
    req(1'b0);
    step();
    step();
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    chk("t5_hold", 32'(seq_state), 4);
    step();
    step();
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk_reset_vals("midrst");
    req(1'b0);
    step();
    chk("t5_reset", 32'(cfg_start), 1);
    wait_status(4, 60);
    chk("t5_lat", n, 21);
    chk("t5_code", 32'(status_code), 0);
    chk("t5_core", 32'(status_core), 0);
    chk("t5_cnt", 32'(reconfig_cnt), 1);
    chk("t5_dis", 32'(core_dis), 0);
    chk("t5_rst", 32'(core_rst), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pr_hrav_reconfig_sequencer.md
PR_HRAV_RECONFIG_SEQUENCER -- requirements
Module: pr_hrav_reconfig_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 4096: max cycles waiting for the target core to go idle.
REQ-002 SHALL have parameter CFG_TIMEOUT, default 1048576: max cycles waiting for configuration completion.
REQ-003 SHALL have parameter RST_HOLD, default 16: cycles core reset stays asserted after configuration completes.
REQ-004 ACLK  in  1  clock; all logic on rising edge.
REQ-005 a_reset  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  reconfiguration request.
REQ-007 req_core  in  1  target scanner core (0/1).
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 core_busy  in  2  per-core packets-in-flight flag.
REQ-010 cfg_start  out  1  one-cycle pulse granting the bitstream path to the ICAP stream.
REQ-011 cfg_done  in  1  one-cycle pulse, configuration finished OK.
REQ-012 cfg_error  in  1  one-cycle pulse, configuration failed.
REQ-013 core_dis  out  2  per-core forced disable (ANDed externally with S/W enable).
REQ-014 core_rst  out  2  per-core forced reset.
REQ-015 status_valid  out  1  one-cycle result pulse.
REQ-016 status_code  out  2  00 OK, 01 drain timeout, 10 cfg error, 11 cfg timeout.
REQ-017 status_core  out  1  core the result refers to.
REQ-018 seq_state  out  3  current FSM state encoding, for regfile debug.
REQ-019 reconfig_cnt  out  16  count of OK completions, wraps FFFF->0000.

Function
REQ-020 FSM states: IDLE=0, DRAIN=1, RESET=2, CONFIG=3, HOLD=4, ENABLE=5, REPORT=6; all outputs registered.
REQ-021 IDLE: req_valid&req_ready latches req_core into tgt, sets core_dis[tgt], clears timer, next DRAIN.
REQ-022 DRAIN: core_busy[tgt]==0 -> RESET; else if timer==DRAIN_TIMEOUT-1 -> REPORT code 01 with core_dis[tgt] cleared; busy dropping on the timeout cycle SHALL win (-> RESET).
REQ-023 RESET: sets core_rst[tgt], drives cfg_start=1 for exactly this one cycle, clears timer, next CONFIG.
REQ-024 CONFIG: cfg_error -> REPORT code 10; else cfg_done -> HOLD with timer cleared; else timer==CFG_TIMEOUT-1 -> REPORT code 11; cfg_error and cfg_done same cycle -> error wins.
REQ-025 On codes 10/11, core_dis[tgt] and core_rst[tgt] SHALL remain set after REPORT until next successful sequence on that core.
REQ-026 HOLD: core_rst[tgt] held; at timer==RST_HOLD-1 clears core_rst[tgt], next ENABLE.
REQ-027 ENABLE: clears core_dis[tgt], increments reconfig_cnt, next REPORT code 00.
REQ-028 REPORT: status_valid=1 one cycle with status_code/status_core, next IDLE.
REQ-029 Other core's core_dis/core_rst bits SHALL never change during a sequence.
REQ-030 cfg_done/cfg_error outside CONFIG SHALL be ignored.
REQ-031 Success latency request-accept to status_valid with core_busy low: 1+1+1+N_cfg+RST_HOLD+1+1 cycles, N_cfg = cycles in CONFIG.
REQ-032 Timer: single counter, width clog2(max(DRAIN_TIMEOUT,CFG_TIMEOUT,RST_HOLD)), cleared on every state entry.

Reset
REQ-033 a_reset SHALL force next-cycle: state IDLE, req_ready 1, cfg_start 0, core_dis 00, core_rst 00, status_valid 0, status_code 00, status_core 0, reconfig_cnt 0, timer 0, tgt 0; mid-sequence reset aborts with no status pulse.

Structure
REQ-034 State encoding and status codes SHALL live in shared package pr_hrav_pkg.
REQ-035 Timer SHALL be sub-module pr_hrav_timeout_cnt (clear, enable, terminal-count compare).

Verification
REQ-036 req core 1, busy low, cfg_done 10 cycles after cfg_start, RST_HOLD=16 -> core_rst[1] high 27 cycles, status 00/core1, reconfig_cnt=1, core_dis=00.
REQ-037 req core 0, core_busy[0] stuck high, DRAIN_TIMEOUT=8 -> status 01 eight cycles after DRAIN entry, cfg_start never pulses, core_dis=00.
REQ-038 cfg_done and cfg_error same cycle on core 0 -> status 10, core_dis=01, core_rst=01 persist in IDLE.
REQ-039 no cfg_done, CFG_TIMEOUT=32 -> status 11 after 32 CONFIG cycles; stray cfg_done in IDLE afterward ignored.
REQ-040 a_reset asserted during HOLD -> next cycle all outputs at reset values, no status_valid; fresh request completes normally.
